// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debugger: opcodes, error codes, controller
// states and the opcode argument-count helper.
package uart_dbg_pkg;

    localparam logic [7:0] OP_READ   = 8'h01;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_PAUSE  = 8'h03;
    localparam logic [7:0] OP_RESUME = 8'h04;
    localparam logic [7:0] OP_STATUS = 8'h05;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BAD_OP  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StPend
    } state_e;

    function automatic logic op_known(input logic [7:0] op);
        case (op)
            OP_READ, OP_WRITE, OP_PAUSE, OP_RESUME, OP_STATUS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Number of 32-bit argument words that follow the opcode.
    function automatic logic [1:0] op_arg_words(input logic [7:0] op);
        case (op)
            OP_READ:  return 2'd1;
            OP_WRITE: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: emits a one-cycle o_Rx_DV pulse with the received byte.
// Has no reset; registers power up idle.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       i_Clock,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    logic [1:0]    sync_q    = 2'b11;
    rx_state_e     state_q   = RxIdle;
    logic [CW-1:0] clk_cnt_q = '0;
    logic [2:0]    bit_idx_q = '0;
    logic [7:0]    byte_q    = '0;
    logic          dv_q      = 1'b0;

    always_ff @(posedge i_Clock) begin
        sync_q <= {sync_q[0], i_Rx_Serial};
        dv_q   <= 1'b0;
        case (state_q)
            RxIdle: begin
                clk_cnt_q <= '0;
                bit_idx_q <= '0;
                if (!sync_q[1]) state_q <= RxStart;
            end
            RxStart: begin
                // Re-check at mid start bit to reject glitches.
                if (clk_cnt_q == CW'((CLKS_PER_BIT - 1) / 2)) begin
                    clk_cnt_q <= '0;
                    state_q   <= sync_q[1] ? RxIdle : RxData;
                end else begin
                    clk_cnt_q <= clk_cnt_q + CW'(1);
                end
            end
            RxData: begin
                if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_q         <= '0;
                    byte_q[bit_idx_q] <= sync_q[1];
                    bit_idx_q         <= bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_q <= RxStop;
                end else begin
                    clk_cnt_q <= clk_cnt_q + CW'(1);
                end
            end
            RxStop: begin
                if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_q <= '0;
                    dv_q      <= sync_q[1];
                    state_q   <= RxIdle;
                end else begin
                    clk_cnt_q <= clk_cnt_q + CW'(1);
                end
            end
            default: state_q <= RxIdle;
        endcase
    end

    assign o_Rx_DV   = dv_q;
    assign o_Rx_Byte = byte_q;

endmodule

// File: rtl/uart_cmd_rx_ctrl.sv
// Receive-side command sequencer: assembles UART bytes into debugger commands
// (opcode, address, data) and presents them over a valid/ready handshake.
module uart_cmd_rx_ctrl
    import uart_dbg_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned TIMEOUT_CLKS = 86800
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_Serial,
    input  logic        i_Cmd_Ready,
    output logic        o_Cmd_Valid,
    output logic [7:0]  o_Cmd_Op,
    output logic [31:0] o_Cmd_Addr,
    output logic [31:0] o_Cmd_Data,
    output logic        o_Err,
    output logic [1:0]  o_Err_Code
);
    localparam int unsigned   TW    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TLast = TW'(TIMEOUT_CLKS - 1);

    logic       rx_dv;
    logic [7:0] rx_byte;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_Clock    (i_Clock),
        .i_Rx_Serial(i_Rx_Serial),
        .o_Rx_DV    (rx_dv),
        .o_Rx_Byte  (rx_byte)
    );

    state_e        state_q;
    logic [7:0]    op_q;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic [1:0]    bcnt_q;
    logic [TW-1:0] tcnt_q;
    logic          err_q;
    logic [1:0]    err_code_q;

    // A pending command being accepted this cycle frees the FSM to take a new opcode.
    logic frame_start;
    assign frame_start = (state_q == StIdle) || (state_q == StPend && i_Cmd_Ready);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            if (frame_start) begin
                state_q <= StIdle;
                if (rx_dv) begin
                    if (!op_known(rx_byte)) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_BAD_OP;
                    end else begin
                        op_q    <= rx_byte;
                        addr_q  <= '0;
                        data_q  <= '0;
                        bcnt_q  <= '0;
                        tcnt_q  <= '0;
                        state_q <= (op_arg_words(rx_byte) == 2'd0) ? StPend : StAddr;
                    end
                end
            end else begin
                case (state_q)
                    StAddr, StData: begin
                        if (rx_dv) begin
                            if (state_q == StAddr) addr_q <= {addr_q[23:0], rx_byte};
                            else                   data_q <= {data_q[23:0], rx_byte};
                            tcnt_q <= '0;
                            bcnt_q <= bcnt_q + 2'd1;
                            if (bcnt_q == 2'd3) begin
                                bcnt_q  <= '0;
                                state_q <= (state_q == StAddr && op_arg_words(op_q) == 2'd2)
                                           ? StData : StPend;
                            end
                        end else if (tcnt_q == TLast) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_TIMEOUT;
                            tcnt_q     <= '0;
                            bcnt_q     <= '0;
                            state_q    <= StIdle;
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                    StPend: begin
                        if (rx_dv) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_OVERRUN;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign o_Cmd_Valid = (state_q == StPend);
    assign o_Cmd_Op    = op_q;
    assign o_Cmd_Addr  = addr_q;
    assign o_Cmd_Data  = data_q;
    assign o_Err       = err_q;
    assign o_Err_Code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_rx_ctrl.sv
// Directed bench for uart_cmd_rx_ctrl: serial frames in, commands and error
// pulses checked against hand-computed values.
module tb_uart_cmd_rx_ctrl;
    localparam int unsigned CPB = 16;
    localparam int unsigned TO  = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        rdy = 1'b0;
    logic        valid;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [1:0]  code;

    uart_cmd_rx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Rx_Serial(rx),
        .i_Cmd_Ready(rdy),
        .o_Cmd_Valid(valid),
        .o_Cmd_Op   (op),
        .o_Cmd_Addr (addr),
        .o_Cmd_Data (data),
        .o_Err      (err),
        .o_Err_Code (code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation counters, sampled mid-cycle.
    int          err_cycles = 0, valid_cycles = 0, accepts = 0, unstable = 0, code_bad = 0;
    int          dv_cyc = 0, rise_cyc = 0, err_cyc = 0;
    logic [1:0]  last_code = 2'b00;
    logic [7:0]  acc_op = 8'h00, acc_op_prev = 8'h00;
    logic [31:0] acc_addr = 32'h0, acc_data = 32'h0;
    logic        pv = 1'b0, pacc = 1'b0;
    logic [7:0]  pop = 8'h00;
    logic [31:0] paddr = 32'h0, pdata = 32'h0;

    always @(negedge clk) begin
        pv    <= valid;
        pacc  <= valid && rdy;
        pop   <= op;
        paddr <= addr;
        pdata <= data;
        if (dut.u_rx.o_Rx_DV) dv_cyc <= cyc;
        if (err) begin
            err_cycles <= err_cycles + 1;
            last_code  <= code;
            err_cyc    <= cyc;
        end else if (code != 2'b00) begin
            code_bad <= code_bad + 1;
        end
        if (valid) begin
            valid_cycles <= valid_cycles + 1;
            if (!pv) rise_cyc <= cyc;
            else if (!pacc && (op != pop || addr != paddr || data != pdata))
                unstable <= unstable + 1;
            if (rdy) begin
                accepts     <= accepts + 1;
                acc_op_prev <= acc_op;
                acc_op      <= op;
                acc_addr    <= addr;
                acc_data    <= data;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            tick(CPB);
        end
    endtask

    int e0, v0, a0, t_rdy;
    logic seen;

    initial begin
        // Reset
        tick(3);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_op", {24'd0, op}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_err", {30'd0, code}, 32'd0);
        rst = 1'b0;
        tick(40);

        // READ 0xDEADBEEF, ready held high
        rdy = 1'b1;
        e0 = err_cycles; v0 = valid_cycles; a0 = accepts;
        send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        tick(10);
        chk("rd_accepts", accepts - a0, 1);
        chk("rd_valid_cycles", valid_cycles - v0, 1);
        chk("rd_latency", rise_cyc - dv_cyc, 1);
        chk("rd_op", {24'd0, acc_op}, 32'h01);
        chk("rd_addr", acc_addr, 32'hDEADBEEF);
        chk("rd_data", acc_data, 32'h0);
        chk("rd_no_err", err_cycles - e0, 0);

        // WRITE with ready low for 5000 clocks
        rdy = 1'b0;
        v0 = valid_cycles; a0 = accepts;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        for (int i = 0; i < 200 && !valid; i++) tick(1);
        chk("wr_valid_up", {31'd0, valid}, 32'd1);
        tick(5000);
        chk("wr_held_op", {24'd0, op}, 32'h02);
        rdy = 1'b1;
        t_rdy = cyc;
        tick(1);
        chk("wr_valid_drop", {31'd0, valid}, 32'd0);
        chk("wr_long_hold", {31'd0, (t_rdy - rise_cyc) >= 5000}, 32'd1);
        chk("wr_valid_cycles", valid_cycles - v0, t_rdy - rise_cyc + 1);
        chk("wr_accepts", accepts - a0, 1);
        chk("wr_addr", acc_addr, 32'h00001000);
        chk("wr_data", acc_data, 32'h12345678);
        chk("wr_stable", unstable, 0);
        tick(10);

        // Bad opcode, then STATUS
        e0 = err_cycles; v0 = valid_cycles; a0 = accepts;
        send_byte(8'h7F);
        tick(10);
        chk("bad_err_pulses", err_cycles - e0, 1);
        chk("bad_code", {30'd0, last_code}, 32'd1);
        chk("bad_no_valid", valid_cycles - v0, 0);
        send_byte(8'h05);
        tick(10);
        chk("st_accepts", accepts - a0, 1);
        chk("st_op", {24'd0, acc_op}, 32'h05);
        chk("st_addr", acc_addr, 32'h0);
        chk("st_data", acc_data, 32'h0);

        // Timeout in the address phase, then PAUSE
        e0 = err_cycles; v0 = valid_cycles; a0 = accepts;
        send_byte(8'h01); send_byte(8'hAA);
        tick(TO + 100);
        chk("to_err_pulses", err_cycles - e0, 1);
        chk("to_code", {30'd0, last_code}, 32'd2);
        // expiry is detected TO cycles after the byte event, pulse registered one later
        chk("to_delay", err_cyc - dv_cyc, TO + 1);
        chk("to_no_valid", valid_cycles - v0, 0);
        send_byte(8'h03);
        tick(10);
        chk("to_next_accepts", accepts - a0, 1);
        chk("to_next_op", {24'd0, acc_op}, 32'h03);

        // Overrun while PAUSE pends, then STATUS arriving with the handshake
        rdy = 1'b0;
        a0 = accepts;
        send_byte(8'h03);
        tick(5);
        e0 = err_cycles;
        send_byte(8'h04);
        tick(5);
        chk("ovr_err_pulses", err_cycles - e0, 1);
        chk("ovr_code", {30'd0, last_code}, 32'd3);
        chk("ovr_valid", {31'd0, valid}, 32'd1);
        chk("ovr_op_kept", {24'd0, op}, 32'h03);
        e0 = err_cycles;
        seen = 1'b0;
        fork
            send_byte(8'h05);
            begin
                for (int i = 0; i < 400; i++) begin
                    tick(1);
                    if (dut.u_rx.o_Rx_DV) begin
                        rdy  = 1'b1;
                        seen = 1'b1;
                        break;
                    end
                end
            end
        join
        tick(5);
        rdy = 1'b0;
        chk("hs_dv_seen", {31'd0, seen}, 32'd1);
        chk("hs_accepts", accepts - a0, 2);
        chk("hs_first_op", {24'd0, acc_op_prev}, 32'h03);
        chk("hs_next_op", {24'd0, acc_op}, 32'h05);
        chk("hs_no_err", err_cycles - e0, 0);

        // Reset mid-address, then a full WRITE
        rdy = 1'b1;
        e0 = err_cycles;
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("mrst_valid", {31'd0, valid}, 32'd0);
        chk("mrst_op", {24'd0, op}, 32'd0);
        chk("mrst_addr", addr, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        a0 = accepts;
        send_byte(8'h02); send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        tick(10);
        chk("mrst_no_err", err_cycles - e0, 0);
        chk("post_accepts", accepts - a0, 1);
        chk("post_op", {24'd0, acc_op}, 32'h02);
        chk("post_addr", acc_addr, 32'hCAFEBABE);
        chk("post_data", acc_data, 32'h01020304);

        chk("err_code_idle_zero", code_bad, 0);
        chk("valid_stable", unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
